// File: rtl/dll_pkg.sv
// Shared definitions for the DLL lock monitor and its helpers.
package dll_pkg;

  localparam int CNT_W = 7;
  localparam logic [CNT_W-1:0] CNT_MAX = 7'd127;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ARM    = 2'd1,
    ST_TRACK  = 2'd2,
    ST_LOCKED = 2'd3
  } dll_state_t;

endpackage

// File: rtl/dll_sync_edge.sv
// Two-flop synchronizer for an asynchronous input, with a rising-edge strobe.
module dll_sync_edge (
  input  logic clock,
  input  logic resetb,
  input  logic din,
  output logic rise
);

  logic s1;
  logic s2;
  logic s3;

  always_ff @(posedge clock) begin
    if (!resetb) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= din;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign rise = s2 & ~s3;

endmodule

// File: rtl/dll_lock_monitor.sv
// Counts DLL output-clock cycles per reference period and reports lock,
// loss of lock and reference stall.
module dll_lock_monitor #(
  parameter int LOCK_COUNT = 4,
  parameter int CNT_W      = dll_pkg::CNT_W
) (
  input  logic             clock,
  input  logic             resetb,
  input  logic             enable,
  input  logic             osc,
  input  logic [4:0]       div,
  input  logic [1:0]       tol,
  input  logic             clear,
  output logic [CNT_W-1:0] count,
  output logic             count_valid,
  output logic             locked,
  output logic             lost
);

  import dll_pkg::*;

  localparam logic [CNT_W-1:0] SAT      = '1;
  localparam logic [3:0]       LOCK_TGT = 4'(LOCK_COUNT);

  logic                    rise;
  logic [CNT_W-1:0]        cnt;
  logic                    sat;
  logic signed [CNT_W:0]   diff;
  logic signed [CNT_W:0]   mag;
  logic                    in_tol;

  dll_state_t              state;
  dll_state_t              state_n;
  logic [3:0]              good;
  logic [3:0]              good_n;
  logic [CNT_W-1:0]        count_n;
  logic                    count_valid_n;
  logic                    locked_n;
  logic                    lost_n;

  dll_sync_edge u_sync (
    .clock  (clock),
    .resetb (resetb),
    .din    (osc),
    .rise   (rise)
  );

  assign sat = (cnt == SAT);

  // Restart at 1 on a rise so a rise N cycles later observes cnt == N.
  always_ff @(posedge clock) begin
    if (!resetb) begin
      cnt <= '0;
    end else if (rise) begin
      cnt <= CNT_W'(1);
    end else if (!sat) begin
      cnt <= cnt + 1'b1;
    end
  end

  always_comb begin
    diff   = $signed({1'b0, cnt}) - $signed({{(CNT_W-4){1'b0}}, div});
    mag    = diff[CNT_W] ? -diff : diff;
    in_tol = (div != '0) && (mag <= $signed({{(CNT_W-1){1'b0}}, tol}));
  end

  always_comb begin
    state_n       = state;
    good_n        = good;
    count_n       = count;
    count_valid_n = 1'b0;
    lost_n        = clear ? 1'b0 : lost;

    if (!enable) begin
      state_n = ST_IDLE;
      good_n  = '0;
    end else begin
      case (state)
        ST_IDLE: begin
          state_n = ST_ARM;
          good_n  = '0;
        end
        ST_ARM: begin
          if (rise) begin
            state_n = ST_TRACK;
          end
        end
        ST_TRACK: begin
          if (rise) begin
            count_n       = cnt;
            count_valid_n = 1'b1;
            if (in_tol) begin
              good_n = good + 4'd1;
              if (good + 4'd1 == LOCK_TGT) begin
                state_n = ST_LOCKED;
              end
            end else begin
              good_n = '0;
            end
          end else if (sat) begin
            state_n = ST_ARM;
            good_n  = '0;
          end
        end
        ST_LOCKED: begin
          if (rise) begin
            count_n       = cnt;
            count_valid_n = 1'b1;
            if (!in_tol) begin
              state_n = ST_TRACK;
              good_n  = '0;
              lost_n  = 1'b1;
            end
          end else if (sat) begin
            state_n = ST_ARM;
            good_n  = '0;
            lost_n  = 1'b1;
          end
        end
        default: begin
          state_n = ST_IDLE;
          good_n  = '0;
        end
      endcase
    end

    locked_n = (state_n == ST_LOCKED);
  end

  always_ff @(posedge clock) begin
    if (!resetb) begin
      state       <= ST_IDLE;
      good        <= '0;
      count       <= '0;
      count_valid <= 1'b0;
      locked      <= 1'b0;
      lost        <= 1'b0;
    end else begin
      state       <= state_n;
      good        <= good_n;
      count       <= count_n;
      count_valid <= count_valid_n;
      locked      <= locked_n;
      lost        <= lost_n;
    end
  end

endmodule

// File: tb/tb_dll_lock_monitor.sv
// Scoreboard bench for dll_lock_monitor: expected measurements are queued
// as reference periods are driven and checked on each count_valid.
module tb_dll_lock_monitor;

  logic       clock  = 1'b0;
  logic       resetb = 1'b0;
  logic       enable = 1'b0;
  logic       osc    = 1'b0;
  logic       clear  = 1'b0;
  logic [4:0] div    = '0;
  logic [1:0] tol    = '0;
  logic [6:0] count;
  logic       count_valid;
  logic       locked;
  logic       lost;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [6:0] cnt;
    logic       lk;
    logic       ls;
  } exp_t;

  exp_t sb[$];

  always #5 clock = ~clock;

  dll_lock_monitor #(.LOCK_COUNT(4), .CNT_W(7)) dut (
    .clock       (clock),
    .resetb      (resetb),
    .enable      (enable),
    .osc         (osc),
    .div         (div),
    .tol         (tol),
    .clear       (clear),
    .count       (count),
    .count_valid (count_valid),
    .locked      (locked),
    .lost        (lost)
  );

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clock);
      if (resetb === 1'b1 && count_valid === 1'b1) begin
        total++;
        if (sb.size() == 0) begin
          bad++;
          $display("FAIL unexpected_valid count=%0d locked=%0b lost=%0b", count, locked, lost);
        end else begin
          e = sb.pop_front();
          if (count !== e.cnt || locked !== e.lk || lost !== e.ls) begin
            bad++;
            $display("FAIL measurement got count=%0d locked=%0b lost=%0b exp count=%0d locked=%0b lost=%0b",
                     count, locked, lost, e.cnt, e.lk, e.ls);
          end
        end
      end
    end
  endtask

  task automatic push(input int c, input logic lk, input logic ls);
    exp_t e;
    e.cnt = 7'(c);
    e.lk  = lk;
    e.ls  = ls;
    sb.push_back(e);
  endtask

  // One reference period of n clocks, starting with the rising edge.
  task automatic pulse(input int n);
    int h;
    h = n / 2;
    if (h < 2) h = 2;
    osc = 1'b1;
    repeat (h) @(negedge clock);
    osc = 1'b0;
    repeat (n - h) @(negedge clock);
  endtask

  task automatic step(input int meas, input logic lk, input logic ls, input int next_len);
    push(meas, lk, ls);
    pulse(next_len);
  endtask

  task automatic do_reset(input logic [4:0] d, input logic [1:0] t);
    sb.delete();
    resetb = 1'b0;
    enable = 1'b0;
    clear  = 1'b0;
    osc    = 1'b0;
    div    = d;
    tol    = t;
    repeat (3) @(negedge clock);
    resetb = 1'b1;
    enable = 1'b1;
  endtask

  task automatic test_reset();
    resetb = 1'b0;
    repeat (3) @(negedge clock);
    total++;
    if (count !== 7'd0 || count_valid !== 1'b0 || locked !== 1'b0 || lost !== 1'b0) begin
      bad++;
      $display("FAIL reset_values got count=%0d valid=%0b locked=%0b lost=%0b exp all 0",
               count, count_valid, locked, lost);
    end
  endtask

  task automatic test_lock_acquire();
    do_reset(5'd8, 2'd0);
    pulse(8);
    step(8, 1'b0, 1'b0, 8);
    step(8, 1'b0, 1'b0, 8);
    step(8, 1'b0, 1'b0, 8);
    step(8, 1'b1, 1'b0, 8);
    total++;
    if (locked !== 1'b1 || lost !== 1'b0 || sb.size() != 0) begin
      bad++;
      $display("FAIL acquire_end got locked=%0b lost=%0b pending=%0d exp locked=1 lost=0 pending=0",
               locked, lost, sb.size());
    end
  endtask

  task automatic test_tolerance();
    do_reset(5'd10, 2'd1);
    pulse(11);
    step(11, 1'b0, 1'b0, 9);
    step(9,  1'b0, 1'b0, 11);
    step(11, 1'b0, 1'b0, 9);
    step(9,  1'b1, 1'b0, 12);
    step(12, 1'b0, 1'b1, 6);
    total++;
    if (locked !== 1'b0 || lost !== 1'b1 || sb.size() != 0) begin
      bad++;
      $display("FAIL tol_drop got locked=%0b lost=%0b pending=%0d exp locked=0 lost=1 pending=0",
               locked, lost, sb.size());
    end
    clear = 1'b1;
    @(negedge clock);
    clear = 1'b0;
    total++;
    if (lost !== 1'b0) begin
      bad++;
      $display("FAIL tol_clear got lost=%0b exp 0", lost);
    end
  endtask

  task automatic test_streak_reset();
    do_reset(5'd6, 2'd0);
    pulse(6);
    step(6, 1'b0, 1'b0, 6);
    step(6, 1'b0, 1'b0, 6);
    step(6, 1'b0, 1'b0, 7);
    step(7, 1'b0, 1'b0, 6);
    step(6, 1'b0, 1'b0, 6);
    step(6, 1'b0, 1'b0, 6);
    step(6, 1'b0, 1'b0, 6);
    step(6, 1'b1, 1'b0, 6);
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL streak_pending got=%0d exp 0", sb.size());
    end
  endtask

  task automatic test_stall();
    do_reset(5'd5, 2'd0);
    pulse(5);
    step(5, 1'b0, 1'b0, 5);
    step(5, 1'b0, 1'b0, 5);
    step(5, 1'b0, 1'b0, 5);
    push(5, 1'b1, 1'b0);
    // Last rise, then the reference stops; saturation lands ~130 clocks later.
    osc = 1'b1;
    repeat (2) @(negedge clock);
    osc = 1'b0;
    repeat (123) @(negedge clock);
    total++;
    if (locked !== 1'b1) begin
      bad++;
      $display("FAIL stall_before_sat got locked=%0b exp 1", locked);
    end
    repeat (10) @(negedge clock);
    total++;
    if (locked !== 1'b0 || lost !== 1'b1 || sb.size() != 0) begin
      bad++;
      $display("FAIL stall_after_sat got locked=%0b lost=%0b pending=%0d exp locked=0 lost=1 pending=0",
               locked, lost, sb.size());
    end
    pulse(5);
    step(5, 1'b0, 1'b1, 5);
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL stall_resume_pending got=%0d exp 0", sb.size());
    end
  endtask

  task automatic test_div_zero();
    do_reset(5'd0, 2'd3);
    pulse(8);
    for (int i = 0; i < 5; i++) step(8, 1'b0, 1'b0, 8);
    total++;
    if (locked !== 1'b0 || sb.size() != 0) begin
      bad++;
      $display("FAIL div_zero got locked=%0b pending=%0d exp locked=0 pending=0", locked, sb.size());
    end
  endtask

  task automatic test_enable_drop();
    do_reset(5'd8, 2'd0);
    pulse(8);
    step(8, 1'b0, 1'b0, 8);
    step(8, 1'b0, 1'b0, 8);
    step(8, 1'b0, 1'b0, 8);
    push(8, 1'b1, 1'b0);
    osc = 1'b1;
    repeat (4) @(negedge clock);
    total++;
    if (locked !== 1'b1) begin
      bad++;
      $display("FAIL en_pre_drop got locked=%0b exp 1", locked);
    end
    osc = 1'b0;
    repeat (2) @(negedge clock);
    enable = 1'b0;
    @(negedge clock);
    total++;
    if (locked !== 1'b0 || count !== 7'd8 || count_valid !== 1'b0) begin
      bad++;
      $display("FAIL en_drop got locked=%0b count=%0d valid=%0b exp locked=0 count=8 valid=0",
               locked, count, count_valid);
    end
    enable = 1'b1;
    pulse(8);
    step(8, 1'b0, 1'b0, 8);
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL en_rearm_pending got=%0d exp 0", sb.size());
    end
  endtask

  task automatic test_sticky_and_reset();
    do_reset(5'd8, 2'd0);
    pulse(8);
    step(8, 1'b0, 1'b0, 8);
    step(8, 1'b0, 1'b0, 8);
    step(8, 1'b0, 1'b0, 8);
    step(8, 1'b1, 1'b0, 10);
    push(10, 1'b0, 1'b1);
    clear = 1'b1;
    osc   = 1'b1;
    repeat (3) @(negedge clock);
    clear = 1'b0;
    @(negedge clock);
    total++;
    if (lost !== 1'b1 || locked !== 1'b0 || sb.size() != 0) begin
      bad++;
      $display("FAIL sticky_priority got lost=%0b locked=%0b pending=%0d exp lost=1 locked=0 pending=0",
               lost, locked, sb.size());
    end
    osc = 1'b0;
    repeat (3) @(negedge clock);
    resetb = 1'b0;
    @(negedge clock);
    resetb = 1'b1;
    total++;
    if (count !== 7'd0 || count_valid !== 1'b0 || locked !== 1'b0 || lost !== 1'b0) begin
      bad++;
      $display("FAIL short_reset got count=%0d valid=%0b locked=%0b lost=%0b exp all 0",
               count, count_valid, locked, lost);
    end
  endtask

  initial begin
    fork
      monitor();
    join_none
    @(negedge clock);
    test_reset();
    test_lock_acquire();
    test_tolerance();
    test_streak_reset();
    test_stall();
    test_div_zero();
    test_enable_drop();
    test_sticky_and_reset();
    repeat (2) @(negedge clock);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dll_lock_monitor.md
# dll_lock_monitor

- Measures the digital locked loop output clock against the reference oscillator by counting output-clock cycles per reference period.
- Compares each measurement with the programmed division ratio and reports lock status to the housekeeping/user logic.
- Runs in the output-clock domain, beside the DLL controller, so the loop's result can be checked independently.
- Also flags loss of lock and a stalled reference.

## Interface
Parameters:
- LOCK_COUNT, 4: consecutive in-tolerance measurements required to declare lock (1–15).
- CNT_W, 7: period counter width; saturates at 2^CNT_W−1 = 127.

Ports:
- clock  in  1  DLL output clock (clockp[0]); the only clock.
- resetb  in  1  synchronous, active-low reset.
- enable  in  1  monitor enable; low forces IDLE synchronously.
- osc  in  1  reference oscillator; asynchronous to clock.
- div  in  5  expected clock cycles per osc period.
- tol  in  2  allowed absolute deviation, in cycles.
- clear  in  1  clears sticky `lost`.
- count  out  CNT_W  last valid period measurement.
- count_valid  out  1  one-cycle pulse when `count` updates.
- locked  out  1  lock indication.
- lost  out  1  sticky; set on every LOCKED→TRACK exit.

## Operation
- **Synchronizer:** osc passes two flops (s1, s2); a third flop s3 gives rise = s2 & ~s3.
- **Period counter:**
  - Loaded with 1 on rise; otherwise increments, saturating at 127.
  - A rise therefore sees cnt = N for rises N cycles apart.
- **Measurement:** on rise in TRACK or LOCKED, count <= cnt and count_valid pulses.
- **Tolerance check:**
  - in_tol = |cnt − {2'b0,div}| <= tol, computed in CNT_W+1-bit signed arithmetic.
  - div == 0 makes in_tol always 0.
- **good counter:** 4 bits.
- **States:**
  - IDLE (reset or enable=0): locked=0, good=0, count_valid=0. Goes to ARM when enable=1.
  - ARM: waits for the first rise. That rise only loads the counter; no measurement is taken. Then goes to TRACK.
  - TRACK, on rise:
    - in_tol: good++. When good reaches LOCK_COUNT, go to LOCKED and set locked=1.
    - otherwise: good=0.
  - LOCKED, on rise with !in_tol: go to TRACK, locked=0, good=0, lost=1.
  - Saturation (cnt reaches 127) in TRACK or LOCKED:
    - Go to ARM, good=0, locked=0, no count_valid.
    - Also set lost=1 if leaving LOCKED.
- **lost:** cleared by clear=1. If set and clear coincide, set wins.
- **enable falling mid-measurement:**
  - Aborts to IDLE next cycle.
  - count and lost are retained.
  - The synchronizer keeps running.

## Timing
- **Reset values:** count=0, count_valid=0, locked=0, lost=0, state=IDLE, cnt=0, s1/s2/s3=0.
- **Latency:** osc first sampled high at clock edge k → rise true after edge k+1 → count/count_valid/locked update at edge k+2, visible in the cycle after.
- **locked:** asserts in the same cycle as the count_valid pulse of the LOCK_COUNT-th consecutive good measurement. Deasserts in the same cycle as the first bad count_valid, or the cycle after saturation.
- **osc width:** must be high and low for ≥2 clock cycles each to be resolved; narrower pulses may be missed (not an error).
- **Changing div/tol:** takes effect at the next rise; no resynchronization needed (quasi-static).

## Structure
- Shared package dll_pkg:
  - state encoding (IDLE=0, ARM=1, TRACK=2, LOCKED=3);
  - CNT_W;
  - CNT_MAX = 127.
- Sub-module dll_sync_edge: two-flop synchronizer plus rising-edge detect, synchronous active-low reset, output `rise`. Reusable for other asynchronous inputs in the clocking block.
- Top-level dll_lock_monitor holds the counter, comparator and FSM (~150–200 lines).

## Test plan
- **Lock acquisition:** div=8, tol=0, LOCK_COUNT=4, osc period exactly 8 clocks.
  - First rise: no count_valid.
  - Next rises: count=8 each time.
  - locked=1 on the 4th count_valid; lost stays 0.
- **Tolerance edge:** div=10, tol=1.
  - Periods 11,9,11,9 → lock.
  - Then a period of 12 → locked=0, lost=1.
  - Then clear=1 → lost=0.
- **Streak reset:** div=6, tol=0, periods 6,6,6,7,6,6,6,6 → locked asserts only on the 8th measurement.
- **Reference stall:** locked with div=5, then osc held low.
  - After cnt reaches 127: locked=0, lost=1, state ARM, no count_valid.
  - On resumption, the first rise is discarded.
- **Controls:**
  - div=0 with any osc → locked never asserts.
  - enable dropped mid-period → locked=0 next cycle, count retained.
  - resetb=0 for one cycle → all outputs 0.
- **Sticky priority:** clear=1 held during the LOCKED→TRACK exit → lost=1 after that cycle.
